// File: rtl/rom_loader.sv
// ROM download to SDRAM write bridge: remaps 16 KB ioctl pages onto SDRAM pages/banks,
// buffers bytes in a small FIFO and issues one req/ack write per byte.
module rom_loader #(
  parameter int         FIFO_AW   = 3,
  parameter logic [7:0] ROM_INDEX = 8'h00,
  parameter logic [8:0] MF2_PAGE  = 9'h1ff
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_bank,
  output logic [7:0]  mem_dout,
  output logic        busy,
  output logic        done,
  output logic        err_map,
  output logic        err_ovf,
  output logic [7:0]  pages_loaded
);

  localparam int               DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_DEPTH    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] C_WAIT_LVL = (FIFO_AW + 1)'(DEPTH - 2);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t             r_state;
  logic [32:0]        r_fifo [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_wait;
  logic               r_mem_req;
  logic [22:0]        r_mem_addr;
  logic [1:0]         r_mem_bank;
  logic [7:0]         r_mem_dout;
  logic               r_busy;
  logic               r_done;
  logic               r_err_map;
  logic               r_err_ovf;
  logic [7:0]         r_pages;
  logic               r_dl_prev;

  logic               w_dl_match;
  logic               w_dl_rise;
  logic               w_accept;
  logic [10:0]        w_page;
  logic               w_mapped;
  logic [8:0]         w_hi;
  logic [32:0]        w_entry;
  logic [32:0]        w_head;
  logic [7:0]         w_onehot;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [FIFO_AW:0]   w_count_next;
  logic               w_busy_next;

  assign w_dl_match = ioctl_download & (ioctl_index == ROM_INDEX);
  assign w_dl_rise  = w_dl_match & ~r_dl_prev;
  assign w_accept   = ioctl_wr & w_dl_match;
  assign w_page     = ioctl_addr[24:14];
  assign w_mapped   = (w_page[10:3] == 8'd0);
  assign w_onehot   = 8'd1 << w_page[2:0];

  always_comb begin
    w_hi = 9'h000;
    case (w_page[1:0])
      2'd0: w_hi = 9'h000;
      2'd1: w_hi = 9'h100;
      2'd2: w_hi = 9'h107;
      2'd3: w_hi = MF2_PAGE;
      default: w_hi = 9'h000;
    endcase
  end

  assign w_entry = {1'b0, w_page[2], w_hi, ioctl_addr[13:0], ioctl_dout};
  assign w_head  = r_fifo[r_rd_ptr];
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = w_accept & w_mapped & ~w_full;
  assign w_pop   = (r_state == S_WAIT) & mem_ack;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_next = r_count - 1'b1;
  end

  // Busy holds until the last queued byte has been acknowledged by SDRAM.
  always_comb begin
    w_busy_next = r_busy;
    if (w_dl_rise)
      w_busy_next = 1'b1;
    else if (!ioctl_download && w_empty && (r_state == S_IDLE))
      w_busy_next = 1'b0;
  end

  // Storage array kept reset-free so it maps onto distributed RAM.
  always_ff @(posedge clk_sys) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_wait    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_map <= 1'b0;
      r_err_ovf <= 1'b0;
      r_pages   <= 8'd0;
      r_dl_prev <= 1'b0;
    end else begin
      r_dl_prev <= w_dl_match;
      r_count   <= w_count_next;
      r_wait    <= (w_count_next >= C_WAIT_LVL);
      r_busy    <= w_busy_next;
      r_done    <= r_busy & ~w_busy_next;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_err_map <= (w_dl_rise ? 1'b0 : r_err_map) | (w_accept & ~w_mapped);
      r_err_ovf <= (w_dl_rise ? 1'b0 : r_err_ovf) | (w_accept & w_mapped & w_full);
      r_pages   <= (w_dl_rise ? 8'd0 : r_pages) | (w_push ? w_onehot : 8'd0);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_bank <= '0;
      r_mem_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_mem_bank, r_mem_addr, r_mem_dout} <= w_head;
            r_mem_req <= 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_wait   = r_wait;
  assign mem_req      = r_mem_req;
  assign mem_addr     = r_mem_addr;
  assign mem_bank     = r_mem_bank;
  assign mem_dout     = r_mem_dout;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_map      = r_err_map;
  assign err_ovf      = r_err_ovf;
  assign pages_loaded = r_pages;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: queue-based model of accepted bytes and status flags, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rom_loader;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [22:0] mem_addr;
  logic [1:0]  mem_bank;
  logic [7:0]  mem_dout;
  logic        busy;
  logic        done;
  logic        err_map;
  logic        err_ovf;
  logic [7:0]  pages_loaded;

  rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_dout(mem_dout),
    .busy(busy), .done(done), .err_map(err_map), .err_ovf(err_ovf),
    .pages_loaded(pages_loaded)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the queue holds every byte the loader owes SDRAM, in order, until acked.
  logic [32:0] exp_q[$];
  logic        m_busy = 1'b0, m_done = 1'b0, m_err_map = 1'b0, m_err_ovf = 1'b0, m_prev = 1'b0;
  logic [7:0]  m_pages = 8'd0;
  int          n_written = 0;
  int          n_req = 0;
  logic [8:0]  page_base [4] = '{9'h000, 9'h100, 9'h107, 9'h1ff};

  function automatic logic [32:0] map_entry(input logic [24:0] a, input logic [7:0] d);
    int p;
    int off;
    logic [22:0] sa;
    p   = int'(a) / 16384;
    off = int'(a) % 16384;
    sa  = 23'(int'(page_base[p % 4]) * 16384 + off);
    return {2'(p / 4), sa, d};
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    logic match, rise, full, empty_pre, nb;
    int p;
    if (reset) begin
      exp_q.delete();
      m_busy = 0; m_done = 0; m_err_map = 0; m_err_ovf = 0; m_prev = 0; m_pages = 0;
    end else begin
      match     = ioctl_download && (ioctl_index == 8'h00);
      rise      = match && !m_prev;
      m_prev    = match;
      full      = (exp_q.size() == 8);
      empty_pre = (exp_q.size() == 0);
      if (rise) begin
        m_err_map = 0; m_err_ovf = 0; m_pages = 0;
      end
      if (mem_ack && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_written++;
      end
      if (ioctl_wr && match) begin
        p = int'(ioctl_addr) / 16384;
        if (p > 7) m_err_map = 1;
        else if (full) m_err_ovf = 1;
        else begin
          exp_q.push_back(map_entry(ioctl_addr, ioctl_dout));
          m_pages[p] = 1'b1;
        end
      end
      nb = rise ? 1'b1 : ((!ioctl_download && empty_pre) ? 1'b0 : m_busy);
      m_done = m_busy && !nb;
      m_busy = nb;
    end
  end

  // SDRAM responder: acks 5 cycles after each request rises.
  int ack_cnt = 0;
  always @(posedge clk_sys) begin
    #1;
    if (reset) begin
      mem_ack = 0; ack_cnt = 0;
    end else if (mem_ack) mem_ack = 0;
    else if (mem_req) begin
      ack_cnt++;
      if (ack_cnt == 5) begin mem_ack = 1; ack_cnt = 0; end
    end
  end

  logic        chk_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [32:0] latched = '0;
  always @(negedge clk_sys) begin
    if (chk_en) begin
      if (mem_req && !prev_req) begin
        n_req++;
        latched = {mem_bank, mem_addr, mem_dout};
        if (exp_q.size() == 0) chk("req_spurious", 40'(mem_req), 40'd0);
        else chk("req_entry", 40'({mem_bank, mem_addr, mem_dout}), 40'(exp_q[0]));
      end else if (mem_req) begin
        chk("req_stable", 40'({mem_bank, mem_addr, mem_dout}), 40'(latched));
      end
      prev_req = mem_req;
      chk("wait", 40'(ioctl_wait), 40'(exp_q.size() >= 6));
      chk("busy", 40'(busy), 40'(m_busy));
      chk("done", 40'(done), 40'(m_done));
      chk("err_map", 40'(err_map), 40'(m_err_map));
      chk("err_ovf", 40'(err_ovf), 40'(m_err_ovf));
      chk("pages", 40'(pages_loaded), 40'(m_pages));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    tick();
    ioctl_wr = 0;
  endtask

  task automatic wait_req();
    int g = 0;
    while (!mem_req && g < 50) begin tick(); g++; end
    chk("req_timeout", 40'(mem_req), 40'd1);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 1000) begin tick(); g++; end
    chk("done_timeout", 40'(done), 40'd1);
  endtask

  initial begin
    int w0, r0, sent, guard;
    logic saw_wait;
    tick(); tick();
    chk("rst_req", 40'(mem_req), 40'd0);
    chk("rst_busy", 40'(busy), 40'd0);
    chk("rst_wait", 40'(ioctl_wait), 40'd0);
    chk("rst_addr", 40'({mem_bank, mem_addr, mem_dout}), 40'd0);
    reset = 0;
    tick();
    chk_en = 1;

    // Single byte, strobe coincides with the download rising edge.
    ioctl_download = 1;
    strobe(25'h04005, 8'hA5);
    ioctl_download = 0;
    chk("t1_busy", 40'(busy), 40'd1);
    wait_req();
    chk("t1_addr", 40'(mem_addr), 40'h400005);
    chk("t1_bank", 40'(mem_bank), 40'd0);
    chk("t1_dout", 40'(mem_dout), 40'hA5);
    chk("t1_pages", 40'(pages_loaded), 40'h02);
    wait_done();
    chk("t1_busy_low", 40'(busy), 40'd0);

    // MF2 page in bank 1.
    ioctl_download = 1;
    tick();
    strobe(25'h1C010, 8'h3C);
    ioctl_download = 0;
    wait_req();
    chk("t2_addr", 40'(mem_addr), 40'h7FC010);
    chk("t2_bank", 40'(mem_bank), 40'd1);
    chk("t2_pages", 40'(pages_loaded), 40'h80);
    wait_done();

    // 64-byte stream honouring ioctl_wait, crossing the page 0 -> 1 boundary.
    w0 = n_written; sent = 0; guard = 0; saw_wait = 0;
    ioctl_download = 1;
    tick();
    while (sent < 64 && guard < 3000) begin
      if (ioctl_wait) begin
        saw_wait = 1; ioctl_wr = 0;
      end else begin
        ioctl_wr = 1; ioctl_addr = 25'h03FE0 + 25'(sent); ioctl_dout = 8'(sent + 16);
        sent++;
      end
      tick();
      guard++;
    end
    ioctl_wr = 0;
    ioctl_download = 0;
    wait_done();
    chk("t3_sent", 40'(sent), 40'd64);
    chk("t3_written", 40'(n_written - w0), 40'd64);
    chk("t3_wait_seen", 40'(saw_wait), 40'd1);
    chk("t3_ovf", 40'(err_ovf), 40'd0);
    chk("t3_pages", 40'(pages_loaded), 40'h03);

    // Same stream ignoring ioctl_wait.
    w0 = n_written;
    ioctl_download = 1;
    tick();
    for (int i = 0; i < 64; i++) strobe(25'h03FE0 + 25'(i), 8'(i + 128));
    ioctl_download = 0;
    wait_done();
    chk("t4_ovf", 40'(err_ovf), 40'd1);
    chk("t4_dropped", 40'((n_written - w0) < 64), 40'd1);

    // Unmapped page.
    r0 = n_req;
    ioctl_download = 1;
    tick();
    strobe(25'h20000, 8'h77);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_err_map", 40'(err_map), 40'd1);
    chk("t5_no_req", 40'(n_req - r0), 40'd0);
    ioctl_download = 0;
    wait_done();
    ioctl_download = 1;
    tick(); tick();
    chk("t5_err_clr", 40'(err_map), 40'd0);
    ioctl_download = 0;
    wait_done();

    // Reset during an outstanding request.
    ioctl_download = 1;
    tick();
    for (int i = 0; i < 4; i++) strobe(25'h08000 + 25'(i), 8'(i + 200));
    ioctl_download = 0;
    wait_req();
    tick();
    reset = 1;
    #1;
    chk("t6_req", 40'(mem_req), 40'd0);
    chk("t6_out", 40'({mem_bank, mem_addr, mem_dout}), 40'd0);
    chk("t6_busy", 40'(busy), 40'd0);
    chk("t6_pages", 40'(pages_loaded), 40'd0);
    chk("t6_wait", 40'(ioctl_wait), 40'd0);
    tick();
    reset = 0;
    r0 = n_req;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_busy_after", 40'(busy), 40'd0);
    chk("t6_no_req", 40'(n_req - r0), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
